// File: rtl/adc_pkg.sv
// Shared widths, scan FSM encoding and the round-robin channel step used by
// the ADC128S052 scan controller and its averaging bank.
package adc_pkg;
  localparam int ADC_W = 12;
  localparam int CH_W  = 3;
  localparam int N_CH  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    WAIT_RDY = 2'd2,
    ACK      = 2'd3
  } scan_state_t;

  // Next enabled channel above cur, wrapping 7->0; returns cur when it is the only one.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] cur,
                                              input logic [N_CH-1:0] mask);
    logic [CH_W-1:0] cand;
    next_ch = cur;
    for (int k = N_CH - 1; k >= 1; k--) begin
      cand = cur + CH_W'(k);
      if (mask[cand]) next_ch = cand;
    end
  endfunction
endpackage

// File: rtl/adc_avg_bank.sv
// Per-channel accumulate-and-count bank; emits a registered result strobe when
// a channel has collected 2^AVG_LOG2 samples.
module adc_avg_bank
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [CH_W-1:0]  i_ch,
  input  logic [ADC_W-1:0] i_data,
  output logic             o_done,
  output logic [CH_W-1:0]  o_ch,
  output logic [ADC_W-1:0] o_data
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [N_CH*ACC_W-1:0] w_acc_flat;
  logic [N_CH*CNT_W-1:0] w_cnt_flat;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_last;
  logic                  r_done;
  logic [CH_W-1:0]       r_ch;
  logic [ADC_W-1:0]      r_data;

  assign w_sum  = w_acc_flat[i_ch*ACC_W +: ACC_W] + ACC_W'(i_data);
  assign w_last = (w_cnt_flat[i_ch*CNT_W +: CNT_W] == CNT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] r_acc;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else if (i_we && (i_ch == CH_W'(gi))) begin
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_acc_flat[gi*ACC_W +: ACC_W] = r_acc;
      assign w_cnt_flat[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_ch   <= '0;
      r_data <= '0;
    end else begin
      r_done <= i_we && w_last;
      if (i_we && w_last) begin
        r_ch   <= i_ch;
        r_data <= ADC_W'(w_sum >> AVG_LOG2);
      end
    end
  end

  assign o_done = r_done;
  assign o_ch   = r_ch;
  assign o_data = r_data;
endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin channel sequencer for the ADC128S052 capture stage: accounts for
// the one-conversion address pipeline, averages per channel, streams results.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter logic [N_CH-1:0] CH_MASK  = 8'hFF,
  parameter int              AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             adc_ready,
  input  logic [ADC_W-1:0] d_signal,
  output logic             ctl_valid,
  output logic             adc_ack,
  output logic [CH_W-1:0]  address,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH_W-1:0]  res_ch,
  output logic [ADC_W-1:0] res_data,
  output logic             overrun
);
  localparam logic [CH_W-1:0] FIRST_CH = next_ch(CH_W'(N_CH - 1), CH_MASK);

  scan_state_t      r_state;
  logic             r_rdy_meta;
  logic             r_rdy_s;
  logic             r_ack;
  logic [CH_W-1:0]  r_addr;
  logic [CH_W-1:0]  r_prev_ch;
  logic             r_res_valid;
  logic [CH_W-1:0]  r_res_ch;
  logic [ADC_W-1:0] r_res_data;
  logic             r_overrun;
  logic             w_capture;
  logic             w_clr;
  logic             w_done;
  logic [CH_W-1:0]  w_done_ch;
  logic [ADC_W-1:0] w_done_data;

  assign w_capture = (r_state == WAIT_RDY) && r_rdy_s;
  assign w_clr     = (r_state == IDLE) && en && (CH_MASK != '0);

  // adc_ready comes from the divided sclk domain logic; resample before use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdy_meta <= 1'b0;
      r_rdy_s    <= 1'b0;
    end else begin
      r_rdy_meta <= adc_ready;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_addr    <= '0;
      r_prev_ch <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_clr) begin
            r_addr  <= FIRST_CH;
            r_state <= PRIME;
          end
        end
        // PRIME differs from WAIT_RDY only in that its sample is not written.
        PRIME, WAIT_RDY: begin
          if (r_rdy_s) begin
            r_ack     <= 1'b1;
            r_prev_ch <= r_addr;
            r_addr    <= next_ch(r_addr, CH_MASK);
            r_state   <= ACK;
          end
        end
        ACK: begin
          if (!r_rdy_s) begin
            r_ack   <= 1'b0;
            r_state <= en ? WAIT_RDY : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  adc_avg_bank #(.AVG_LOG2(AVG_LOG2)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_we   (w_capture),
    .i_ch   (r_prev_ch),
    .i_data (d_signal),
    .o_done (w_done),
    .o_ch   (w_done_ch),
    .o_data (w_done_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_data  <= '0;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      if (r_res_valid && !res_ready) begin
        r_overrun <= 1'b1;
      end else begin
        r_res_valid <= 1'b1;
        r_res_ch    <= w_done_ch;
        r_res_data  <= w_done_data;
      end
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign ctl_valid = (r_state != IDLE);
  assign adc_ack   = r_ack;
  assign address   = r_addr;
  assign res_valid = r_res_valid;
  assign res_ch    = r_res_ch;
  assign res_data  = r_res_data;
  assign overrun   = r_overrun;
endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Channel sequencer and averager that sits directly downstream of the ADC128S052 capture stage. It drives the capture stage's `ctl_valid`, `address` and `adc_ack`, and consumes `adc_ready`/`d_signal`. Enabled channels are stepped round-robin. The ADC's one-conversion address pipeline is accounted for, each channel is averaged over 2^AVG_LOG2 samples, and results go out on a valid/ready stream to the control logic.

## Interface
- `CH_MASK`, 8'hFF: enabled channels, bit i = IN i.
- `AVG_LOG2`, 2: log2 of samples averaged per result, legal 0..4.
- `clk`  in  1  system clock, same clock that feeds the capture stage.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  scan enable (level).
- `adc_ready`  in  1  conversion done, from capture stage.
- `d_signal`  in  12  conversion result, from capture stage.
- `ctl_valid`  out  1  run request to capture stage.
- `adc_ack`  out  1  result consumed, to capture stage.
- `address`  out  3  channel to convert, to capture stage.
- `res_valid`  out  1  averaged result available.
- `res_ready`  in  1  downstream accepts result.
- `res_ch`  out  3  channel of `res_data`.
- `res_data`  out  12  averaged sample.
- `overrun`  out  1  sticky; a result was dropped because `res_valid` was still pending.

## Operation
- `adc_ready` is toggled from the divided clock. It passes through a 2-flop synchronizer (`rdy_s`) before any use.
- **Pipeline rule.** The address sent during conversion N selects the channel of conversion N+1.
  - `prev_ch` holds the address that was active during the last conversion.
  - The sample returned at conversion end belongs to `prev_ch`.
- **FSM states:** IDLE, PRIME, WAIT_RDY, ACK.
  - IDLE: `ctl_valid`=0. If `en`=1 and CH_MASK≠0: clear all accumulators and counts, set `address` = lowest enabled channel, go to PRIME.
  - PRIME: first conversion after start. The channel it returns is undefined, so the sample is discarded.
    - On `rdy_s`=1: assert `adc_ack`, load `prev_ch`=`address`, step `address`, go to ACK.
  - WAIT_RDY: on `rdy_s`=1:
    - capture `d_signal` into the accumulator of `prev_ch`;
    - load `prev_ch`=`address`;
    - step `address` to the next enabled channel ascending, wrapping 7→0;
    - assert `adc_ack`; go to ACK.
  - ACK: hold `adc_ack`=1 until `rdy_s`=0, then deassert it. Go to WAIT_RDY if `en`=1, else IDLE.
- `ctl_valid` = 1 in PRIME, WAIT_RDY and ACK. `en` falling mid-conversion does not abort; the current conversion completes with its handshake.
- **Accumulation.**
  - Accumulator width is 12+AVG_LOG2, with an AVG_LOG2-bit count per channel.
  - When the count reaches 2^AVG_LOG2−1 on a capture: result = (acc + d_signal) >> AVG_LOG2, truncated. Accumulator and count clear.
- **Emission.** The result loads `res_data`/`res_ch` and sets `res_valid`.
  - If `res_valid` is already 1 without `res_ready` in that cycle: the new result is dropped, `overrun` is set, and the held result is unchanged.
  - If `res_valid`&&`res_ready` happen in the same cycle as a new result, the new result loads and no overrun is flagged.
- CH_MASK=0: block stays in IDLE permanently.
- A single enabled channel means `address` stays constant.

## Timing
- Reset values (rst=0 at a clk edge): state IDLE; `ctl_valid`, `adc_ack`, `res_valid` and `overrun` = 0; `address`, `res_ch` and `res_data` = 0; accumulators, counts, `prev_ch` and synchronizer = 0. Reset mid-handshake abandons it immediately.
- `adc_ready` rising to capture: 2 clk (synchronizer) + 1 clk (FSM register). `adc_ack` is registered and rises in the same cycle the capture is written.
- `adc_ack` falls 1 clk after `rdy_s` is seen low, i.e. ≤3 clk after `adc_ready` falls.
- `res_valid` rises 1 clk after the completing capture. It falls on the edge after `res_valid`&&`res_ready`.
- `address` changes only in the capture cycle. The capture stage must be given a new address with ≥1 sclk margin; the pause of ≥10 sclk covers this.
- `overrun` clears only on reset.

## Structure
- Package `adc_pkg`:
  - ADC_W=12, CH_W=3, N_CH=8;
  - the `scan_state_t` enum (IDLE, PRIME, WAIT_RDY, ACK);
  - function `next_ch(cur, mask)` for the round-robin step.
- Sub-module `adc_avg_bank`: 8-entry accumulator/count array with capture port (ch, data, we) and a result strobe output. The FSM, synchronizer and output register live in `adc_scan_ctrl`.

## Test plan
- CH_MASK=8'h05, AVG_LOG2=0, ADC model returns 100+ch → first sample discarded; results alternate ch0=100, ch2=102. `address` sequence 0,2,0,2…
- AVG_LOG2=2, single channel 3, samples 10,11,12,14 → one result, ch3 = 11 (47>>2); accumulator then restarts.
- `res_ready` held 0 across two completed results → first result held, `overrun`=1; with `res_ready`=1 on the completion cycle, the second result loads and `overrun` stays 0.
- `en` dropped while `ctl_valid`=1 and conversion in flight → `adc_ack` pulse completes, then IDLE with `ctl_valid`=0. Re-enable → PRIME again, accumulators cleared.
- `rst`=0 asserted while `adc_ack`=1 → next edge all outputs are at their reset values. CH_MASK=0 → `ctl_valid` never rises.
